// File: rtl/ps2_scancode_rx_if.sv
// rtl/ps2_scancode_rx_if.sv - PS/2 line inputs and scan-code outputs of ps2_scancode_rx
interface ps2_scancode_rx_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] key;
    logic       rdy;
    logic       ext;
    logic       err;

    modport master (output ps2_clk, ps2_dat, input key, rdy, ext, err);
    modport slave  (input ps2_clk, ps2_dat, output key, rdy, ext, err);
endinterface

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 device-to-host frame receiver; optional E0/F0 filter under PS2_BREAK_FILTER_EN
module ps2_scancode_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CLK = 50000
) (
    input  logic               clk,
    input  logic               rst,
    ps2_scancode_rx_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT_CLK);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLK - 1);
    localparam logic [TW-1:0] TONE = TW'(1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    state_t                 state_q, state_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   parity_q, parity_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [7:0]             key_q, key_d;
    logic                   rdy_q, rdy_d;
    logic                   err_q, err_d;
    logic                   clk_s, dat_s, fall, frame_good;
`ifdef PS2_BREAK_FILTER_EN
    logic                   ext_q, ext_d;
    logic                   brk_q, brk_d;
    logic                   e0_q, e0_d;
`endif

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall  = clk_prev_q & ~clk_s;

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], bus.ps2_dat};
        clk_prev_d = clk_s;
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        tcnt_d     = tcnt_q;
        key_d      = key_q;
        rdy_d      = 1'b0;
        err_d      = 1'b0;
        frame_good = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        ext_d      = ext_q;
        brk_d      = brk_q;
        e0_d       = e0_q;
`endif

        // A fall takes priority over an expiring timeout in the same cycle.
        if (fall) begin
            tcnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (!dat_s) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shreg_d  = {dat_s, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = dat_s;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat_s && (^{shreg_q, parity_q})) frame_good = 1'b1;
                    else                                  err_d      = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            tcnt_d = '0;
        end else if (tcnt_q == TMAX) begin
            state_d = IDLE;
            err_d   = 1'b1;
            tcnt_d  = '0;
        end else if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + TONE;
        end

        if (frame_good) begin
`ifdef PS2_BREAK_FILTER_EN
            if (shreg_q == 8'hE0) begin
                e0_d = 1'b1;
            end else if (shreg_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
                e0_d  = 1'b0;
            end else begin
                key_d = shreg_q;
                ext_d = e0_q;
                rdy_d = 1'b1;
                e0_d  = 1'b0;
            end
`else
            key_d = shreg_q;
            rdy_d = 1'b1;
`endif
        end

`ifdef PS2_BREAK_FILTER_EN
        if (err_d) begin
            brk_d = 1'b0;
            e0_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            shreg_q    <= 8'h00;
            parity_q   <= 1'b0;
            tcnt_q     <= '0;
            key_q      <= 8'h00;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            e0_q       <= 1'b0;
`endif
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            tcnt_q     <= tcnt_d;
            key_q      <= key_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
`ifdef PS2_BREAK_FILTER_EN
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            e0_q       <= e0_d;
`endif
        end
    end

    assign bus.key = key_q;
    assign bus.rdy = rdy_q;
    assign bus.err = err_q;
`ifdef PS2_BREAK_FILTER_EN
    assign bus.ext = ext_q;
`else
    assign bus.ext = 1'b0;
`endif
endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
PS/2 device-to-host receiver. Samples the keyboard's ps2_clk/ps2_dat lines in the system clk domain, deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and emits validated scan-code bytes as a one-cycle strobe. Sits directly upstream of key_control: its key/rdy outputs feed key_control's key/key_pressed inputs and the snake_game seed capture.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronisers on ps2_clk and ps2_dat (minimum 2).
TIMEOUT_CLK, 50000, clk cycles without a ps2_clk falling edge before an in-progress frame is aborted.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
ps2_clk  input  1  raw PS/2 clock from the connector, asynchronous
ps2_dat  input  1  raw PS/2 data from the connector, asynchronous
key  output  8  last accepted scan-code byte; held until the next accepted byte
rdy  output  1  one-cycle pulse: key has just been updated
ext  output  1  byte in key was preceded by an E0 prefix (PS2_BREAK_FILTER_EN only; tied 0 otherwise)
err  output  1  one-cycle pulse on parity error, bad stop bit or timeout

Behaviour:
- Reset values: key=8'h00, rdy=0, ext=0, err=0, state=IDLE, bit counter=0, timeout counter=0. All synchroniser flops reset to 1 (idle line level).
- Synchronisers: SYNC_STAGES flops per line. fall = (previous synced ps2_clk == 1) && (synced ps2_clk == 0). Data is sampled from the synced ps2_dat in the same cycle as fall.
- States and transitions:
  - IDLE: on fall with dat=0, go to DATA and clear the bit count. On fall with dat=1, stay in IDLE (spurious edge, no err).
  - DATA: on each fall, shift dat into shreg[7] and shift right, so bits arrive LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, check the frame. It is good when dat=1 and XOR(data bits, parity bit)=1 (odd parity). Good frame: deliver the byte. Bad frame: err=1 for one cycle. Either way, go to IDLE.
- Delivery: rdy and the new key value become visible in the cycle after the fall that sampled the stop bit. This is 1 clk latency from the detected stop edge.
- rdy and err are never high in the same cycle. Both are 0 in every cycle not named above.
- Timeout: the counter clears on every fall and while in IDLE, and increments otherwise. When it reaches TIMEOUT_CLK-1 in any non-IDLE state: go to IDLE, err pulses once, key is unchanged.
- If a fall coincides with the timeout count, the fall wins: it is processed and the counter clears.
- rst mid-frame: the partial frame is discarded with no rdy and no err. The next frame starts clean.
- Width rules: the bit counter is 3 bits. The timeout counter is $clog2(TIMEOUT_CLK) bits and saturates; it does not wrap.

Optional Feature:
Macro: PS2_BREAK_FILTER_EN
- Defined: a decoder stage after deframing, with flags brk and e0.
  - Byte E0: set e0, no rdy.
  - Byte F0: set brk, no rdy.
  - Any other byte with brk=1: suppressed (no rdy); clear brk and e0.
  - Any other byte with brk=0: rdy pulse, key=byte, ext=e0; then clear e0.
  - Only make codes reach key_control.
  - Flags clear on rst and on err.
- Undefined: every good byte, including E0/F0, produces rdy. ext is tied 0.

Test Plan:
- Frame 0x1D with parity=1, stop=1 -> exactly one rdy pulse one clk after the stop-bit fall; key=8'h1D; err=0.
- Frame 0x1D with parity=0 -> err pulses once; no rdy; key keeps its prior value (8'h00 after reset).
- Start bit plus 5 data bits, then ps2_clk held high for TIMEOUT_CLK cycles -> err pulses once; state returns to IDLE. A following good frame 0x1C -> rdy, key=8'h1C.
- rst asserted after 4 data bits of 0x75, then a full frame 0x72 -> no rdy/err for the aborted frame; rdy with key=8'h72.
- With PS2_BREAK_FILTER_EN, sequence 1D, F0, 1D -> one rdy (key=8'h1D). Sequence E0, 75 -> one rdy with key=8'h75, ext=1.
- Without PS2_BREAK_FILTER_EN, sequence 1D, F0, 1D -> three rdy pulses with key=1D, F0, 1D; ext=0 throughout.
